// File: rtl/hilo_pkg.sv
// hilo_pkg: shared word width, unit latencies and state encoding for hilo_ctrl.
// Rev 1.0
`default_nettype none

package hilo_pkg;

  localparam int WORD_W       = 32;
  localparam int DIV_LAT_DEF  = 34;
  localparam int MULT_LAT_DEF = 33;
  localparam int CNT_W_DEF    = 6;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DIV_WAIT  = 3'd1,
    ST_MULT_WAIT = 3'd2,
    ST_DIV_ZERO  = 3'd3,
    ST_DONE      = 3'd4
  } state_e;

endpackage

`default_nettype wire

// File: rtl/hilo_ctrl.sv
// hilo_ctrl: sequences the multicycle divider/multiplier and owns the HI/LO registers.
// Rev 1.0
`default_nettype none

module hilo_ctrl
  import hilo_pkg::*;
#(
  parameter int DIV_LAT  = DIV_LAT_DEF,
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              op_div,
  input  logic              op_mult,
  input  logic              mthi,
  input  logic              mtlo,
  input  logic [WORD_W-1:0] wdata,
  input  logic [WORD_W-1:0] hidiv,
  input  logic [WORD_W-1:0] lodiv,
  input  logic              Div0,
  input  logic [WORD_W-1:0] himult,
  input  logic [WORD_W-1:0] lomult,
  output logic              comecodiv,
  output logic              comecomult,
  output logic              div_rst,
  output logic [WORD_W-1:0] hi,
  output logic [WORD_W-1:0] lo,
  output logic              busy,
  output logic              done,
  output logic              div0_exc
);

  localparam logic [CNT_W-1:0] DIV_LAT_C  = CNT_W'(DIV_LAT);
  localparam logic [CNT_W-1:0] MULT_LAT_C = CNT_W'(MULT_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic [WORD_W-1:0] hi_q;
  logic [WORD_W-1:0] lo_q;
  logic              comecodiv_q;
  logic              comecomult_q;
  logic              busy_q;
  logic              done_q;
  logic              div0_exc_q;
  logic              div_rst_q;

  // Saturating so a stuck unit can never alias back onto a capture count.
  always_comb begin
    cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      hi_q         <= '0;
      lo_q         <= '0;
      comecodiv_q  <= 1'b0;
      comecomult_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      div0_exc_q   <= 1'b0;
      div_rst_q    <= 1'b0;
    end else begin
      comecodiv_q  <= 1'b0;
      comecomult_q <= 1'b0;
      done_q       <= 1'b0;
      div0_exc_q   <= 1'b0;
      div_rst_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          if (mthi) hi_q <= wdata;
          if (mtlo) lo_q <= wdata;
          if (op_div) begin
            comecodiv_q <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= ST_DIV_WAIT;
          end else if (op_mult) begin
            comecomult_q <= 1'b1;
            busy_q       <= 1'b1;
            state_q      <= ST_MULT_WAIT;
          end
        end
        ST_DIV_WAIT: begin
          cnt_q <= cnt_d;
          // Div0 is valid one edge after the divider samples its start pulse.
          if (cnt_q == CNT_ONE && Div0) begin
            div0_exc_q <= 1'b1;
            div_rst_q  <= 1'b1;
            state_q    <= ST_DIV_ZERO;
          end else if (cnt_q == DIV_LAT_C) begin
            hi_q    <= hidiv;
            lo_q    <= lodiv;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_MULT_WAIT: begin
          cnt_q <= cnt_d;
          if (cnt_q == MULT_LAT_C) begin
            hi_q    <= himult;
            lo_q    <= lomult;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign comecodiv  = comecodiv_q;
  assign comecomult = comecomult_q;
  assign div_rst    = reset | div_rst_q;
  assign hi         = hi_q;
  assign lo         = lo_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign div0_exc   = div0_exc_q;

endmodule

`default_nettype wire

// File: tb/tb_hilo_ctrl.sv
// tb_hilo_ctrl: directed and random DIV/MULT/MTHI/MTLO sequences against unit and result models.
// Rev 1.0
`default_nettype none

module tb_hilo_ctrl;

  localparam int DL = 34;
  localparam int ML = 33;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        op_div = 1'b0;
  logic        op_mult = 1'b0;
  logic        mthi = 1'b0;
  logic        mtlo = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] hidiv = '0;
  logic [31:0] lodiv = '0;
  logic        Div0 = 1'b0;
  logic [31:0] himult = '0;
  logic [31:0] lomult = '0;
  logic        comecodiv;
  logic        comecomult;
  logic        div_rst;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div0_exc;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;
  logic [31:0] opa = '0;
  logic [31:0] opb = '0;

  hilo_ctrl dut (
    .clock(clock), .reset(reset), .op_div(op_div), .op_mult(op_mult),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .hidiv(hidiv), .lodiv(lodiv),
    .Div0(Div0), .himult(himult), .lomult(lomult), .comecodiv(comecodiv),
    .comecomult(comecomult), .div_rst(div_rst), .hi(hi), .lo(lo),
    .busy(busy), .done(done), .div0_exc(div0_exc)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Divider quotient truncates toward zero; the remainder is the magnitude remainder.
  function automatic logic [63:0] div_ref(input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q  = sa / sb;
    r  = (sa < 0 ? -sa : sa) % (sb < 0 ? -sb : sb);
    return {r[31:0], q[31:0]};
  endfunction

  function automatic logic [63:0] mul_ref(input logic [31:0] a, input logic [31:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return p;
  endfunction

  // Divider model: start sample counts as edge 1, results appear after edge DL.
  // A zero divisor raises Div0 and parks the unit until div_rst.
  int          dk = 0;
  bit          drun = 1'b0;
  bit          dpark = 1'b0;
  logic [31:0] da = '0, db = '0;
  always @(posedge clock) begin
    if (div_rst) begin
      drun <= 1'b0; dpark <= 1'b0; dk <= 0; Div0 <= 1'b0;
    end else if (comecodiv && !drun && !dpark) begin
      da <= opa; db <= opb;
      hidiv <= 32'hDEAD_BEEF; lodiv <= 32'hDEAD_BEEF;
      if (opb == 0) begin
        Div0 <= 1'b1; dpark <= 1'b1;
      end else begin
        drun <= 1'b1; dk <= 1;
      end
    end else if (drun) begin
      if (dk + 1 == DL) begin
        {hidiv, lodiv} <= div_ref(da, db);
        drun <= 1'b0;
      end else begin
        dk <= dk + 1;
      end
    end
  end

  int          mk = 0;
  bit          mrun = 1'b0;
  logic [31:0] ma = '0, mb = '0;
  always @(posedge clock) begin
    if (reset) begin
      mrun <= 1'b0; mk <= 0;
    end else if (comecomult && !mrun) begin
      ma <= opa; mb <= opb; mrun <= 1'b1; mk <= 1;
      himult <= 32'hBAD0_BAD0; lomult <= 32'hBAD0_BAD0;
    end else if (mrun) begin
      if (mk + 1 == ML) begin
        {himult, lomult} <= mul_ref(ma, mb);
        mrun <= 1'b0;
      end else begin
        mk <= mk + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One request held until busy is seen; monitors every cycle until busy drops.
  task automatic run_op(input string tag, input bit dodiv, input bit domult,
                        input logic [31:0] a, input logic [31:0] b,
                        input bit mv_req, input bit mv_mid);
    int          n, busy_n, cd_n, cd_at, cm_n, cm_at, done_n, done_at, exc_n, exc_at, drst_at;
    int          lat;
    bit          zero;
    logic [31:0] hold_hi;
    logic [63:0] r;
    n = 0; busy_n = 0; cd_n = 0; cd_at = -1; cm_n = 0; cm_at = -1;
    done_n = 0; done_at = -1; exc_n = 0; exc_at = -1; drst_at = -1;
    hold_hi = '0;
    zero = dodiv && (b == 0);
    lat  = dodiv ? DL + 2 : ML + 2;
    r    = dodiv ? (zero ? 64'd0 : div_ref(a, b)) : mul_ref(a, b);
    opa = a; opb = b;
    @(negedge clock);
    op_div = dodiv; op_mult = domult; mthi = mv_req; wdata = 32'h1234_5678;
    if (mv_req) exp_hi = 32'h1234_5678;
    while (n < 80) begin
      @(negedge clock);
      n++;
      if (n == 1) begin
        op_div = 1'b0; op_mult = 1'b0; mthi = 1'b0;
        if (mv_req) chk({tag, "/move_same_edge"}, hi, 32'h1234_5678);
      end
      if (mv_mid && n == 5) begin
        hold_hi = hi; mthi = 1'b1; wdata = 32'hCAFE_F00D;
      end
      if (mv_mid && n == 6) begin
        mthi = 1'b0;
        chk({tag, "/mthi_while_busy"}, hi, hold_hi);
      end
      if (busy) busy_n++;
      if (comecodiv) begin cd_n++; if (cd_at < 0) cd_at = n; end
      if (comecomult) begin cm_n++; if (cm_at < 0) cm_at = n; end
      if (done) begin done_n++; if (done_at < 0) done_at = n; end
      if (div0_exc) begin exc_n++; if (exc_at < 0) exc_at = n; end
      if (div_rst) drst_at = n;
      if (!busy && n > 2) break;
    end
    chk({tag, "/comecodiv_count"}, cd_n, dodiv ? 1 : 0);
    chk({tag, "/comecodiv_cycle"}, cd_at, dodiv ? 1 : -1);
    chk({tag, "/comecomult_count"}, cm_n, dodiv ? 0 : 1);
    chk({tag, "/busy_cycles"}, busy_n, zero ? 3 : lat);
    chk({tag, "/done_count"}, done_n, zero ? 0 : 1);
    chk({tag, "/done_cycle"}, done_at, zero ? -1 : lat);
    chk({tag, "/div0_exc_cycle"}, {exc_n, exc_at}, zero ? {32'd1, 32'd3} : {32'd0, -32'sd1});
    chk({tag, "/div_rst_cycle"}, drst_at, zero ? 3 : -1);
    if (!zero) begin
      exp_hi = r[63:32];
      exp_lo = r[31:0];
    end
    chk({tag, "/hi"}, hi, exp_hi);
    chk({tag, "/lo"}, lo, exp_lo);
  endtask

  initial begin
    int nd, ne;
    logic [31:0] ra, rb;
    bit rdiv;

    repeat (3) @(negedge clock);
    chk("reset/outputs_zero", {hi, lo, comecodiv, comecomult, busy, done, div0_exc}, '0);
    chk("reset/div_rst", div_rst, 1'b1);
    reset = 1'b0;
    @(negedge clock);
    chk("post_reset/div_rst", div_rst, 1'b0);
    chk("post_reset/busy", busy, 1'b0);

    run_op("div_100_7", 1'b1, 1'b0, 32'd100, 32'd7, 1'b0, 1'b0);
    run_op("div_m7_2", 1'b1, 1'b0, -32'sd7, 32'd2, 1'b0, 1'b0);
    run_op("div_by_zero", 1'b1, 1'b0, 32'd55, 32'd0, 1'b0, 1'b0);
    run_op("div_9_3", 1'b1, 1'b0, 32'd9, 32'd3, 1'b0, 1'b0);
    run_op("mult_3_m2", 1'b0, 1'b1, 32'd3, -32'sd2, 1'b0, 1'b0);

    @(negedge clock); mthi = 1'b1; wdata = 32'h5A5A_5A5A;
    @(negedge clock); mthi = 1'b0;
    exp_hi = 32'h5A5A_5A5A;
    chk("mthi/hi", hi, exp_hi);
    chk("mthi/busy", busy, 1'b0);
    mtlo = 1'b1; wdata = 32'd1;
    @(negedge clock); mtlo = 1'b0;
    exp_lo = 32'd1;
    chk("mtlo/lo", lo, exp_lo);
    chk("mtlo/hi_kept", hi, exp_hi);
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'h0000_0077;
    @(negedge clock); mthi = 1'b0; mtlo = 1'b0;
    exp_hi = 32'h77; exp_lo = 32'h77;
    chk("mthi_mtlo/both", {hi, lo}, {exp_hi, exp_lo});

    run_op("div_mthi_busy", 1'b1, 1'b0, 32'd1000, 32'd33, 1'b0, 1'b1);
    run_op("div_and_mult", 1'b1, 1'b1, 32'd50, 32'd6, 1'b0, 1'b0);
    run_op("mult_with_move", 1'b0, 1'b1, 32'd7, 32'd9, 1'b1, 1'b0);

    opa = 32'd100; opb = 32'd7;
    @(negedge clock); op_div = 1'b1;
    @(negedge clock); op_div = 1'b0;
    repeat (10) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("mid_reset/busy", busy, 1'b0);
    chk("mid_reset/hi_lo", {hi, lo}, 64'd0);
    chk("mid_reset/done", done, 1'b0);
    chk("mid_reset/div_rst", div_rst, 1'b1);
    reset = 1'b0;
    exp_hi = '0; exp_lo = '0;
    nd = 0; ne = 0;
    repeat (45) begin
      @(negedge clock);
      if (done) nd++;
      if (div0_exc || busy) ne++;
    end
    chk("mid_reset/no_done", nd, 0);
    chk("mid_reset/idle_quiet", ne, 0);
    run_op("div_after_reset", 1'b1, 1'b0, 32'd100, 32'd7, 1'b0, 1'b0);

    for (int i = 0; i < 6; i++) begin
      rdiv = 1'($urandom % 2);
      ra   = $urandom;
      rb   = ($urandom % 5 == 0) ? 32'd0 : $urandom;
      if (ra == 32'h8000_0000) ra = 32'd1;
      run_op(rdiv ? "rand_div" : "rand_mult", rdiv, !rdiv, ra, rb, 1'b0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
